// File: rtl/alu_ops_pkg.sv
// rtl/alu_ops_pkg.sv - ALU select codes, flag bit positions and arbiter state encoding
package alu_ops_pkg;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_ADD  = 8'h01;
   localparam logic [7:0] OP_SUB  = 8'h02;
   localparam logic [7:0] OP_MULT = 8'h03;
   localparam logic [7:0] OP_DIV  = 8'h04;
   localparam logic [7:0] OP_MOD  = 8'h05;
   localparam logic [7:0] OP_INC  = 8'h06;
   localparam logic [7:0] OP_DEC  = 8'h07;
   localparam logic [7:0] OP_SL   = 8'h08;
   localparam logic [7:0] OP_SR   = 8'h09;
   localparam logic [7:0] OP_AND  = 8'h0A;
   localparam logic [7:0] OP_NAND = 8'h0B;
   localparam logic [7:0] OP_NOR  = 8'h0C;
   localparam logic [7:0] OP_NOT  = 8'h0D;
   localparam logic [7:0] OP_OR   = 8'h0E;
   localparam logic [7:0] OP_XNOR = 8'h0F;
   localparam logic [7:0] OP_XOR  = 8'h10;
   localparam logic [7:0] OP_ROL  = 8'h11;
   localparam logic [7:0] OP_ROR  = 8'h12;
   localparam logic [7:0] OP_CMP  = 8'h18;

   localparam int unsigned ZF = 0;
   localparam int unsigned CF = 1;
   localparam int unsigned SF = 2;
   localparam int unsigned PF = 3;
   localparam int unsigned IF = 4;
   localparam int unsigned DF = 5;
   localparam int unsigned OF = 6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_CAPTURE,
      ST_RESP
   } state_e;

   // OP_NOP is not a requestable operation; the ALU idles on it.
   function automatic logic is_legal_op(input logic [7:0] op);
      return ((op >= OP_ADD) && (op <= OP_ROR)) || (op == OP_CMP);
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant; priority flips only on an accepted grant
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   input  logic [1:0] req_i,
   input  logic [1:0] accept_i,
   output logic [1:0] grant_o
);

   logic last_grant_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= 1'b1;
      end else if (|accept_i) begin
         last_grant_q <= accept_i[1];
      end
   end

   always_comb begin
      grant_o = 2'b00;
      if (en_i) begin
         if (req_i == 2'b11) begin
            grant_o = last_grant_q ? 2'b01 : 2'b10;
         end else begin
            grant_o = req_i;
         end
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU between two requesters, holds inputs to settle, returns captured results
module alu_arbiter
   import alu_ops_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int WIDTH         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [7:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [7:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic [6:0]       rsp_flags,
   output logic [2:0]       rsp_cmp,
   output logic             rsp_err,
   output logic [WIDTH-1:0] alu_operand1,
   output logic [WIDTH-1:0] alu_operand2,
   output logic [7:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_result,
   input  logic [6:0]       alu_flags,
   input  logic             alu_eq,
   input  logic             alu_gt,
   input  logic             alu_lt,
   output logic [6:0]       flags_q,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [1:0]       req_valid, grant, accept;
   logic [7:0]       acc_op;
   logic [WIDTH-1:0] acc_a, acc_b;
   logic             owner_q;
   logic [7:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [3:0]       cnt_q;
   logic             drive_alu, rsp_fire, settle_done;

   assign req_valid = {req1_valid, req0_valid};
   assign accept    = req_valid & grant;
   assign acc_op    = accept[1] ? req1_op : req0_op;
   assign acc_a     = accept[1] ? req1_a  : req0_a;
   assign acc_b     = accept[1] ? req1_b  : req0_b;

   rr_arbiter2 u_arb (
      .clk      (clk),
      .rst      (rst),
      .en_i     (state_q == ST_IDLE),
      .req_i    (req_valid),
      .accept_i (accept),
      .grant_o  (grant)
   );

   assign settle_done = (cnt_q == 4'(SETTLE_CYCLES - 1));
   assign rsp_fire    = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (|accept) state_d = is_legal_op(acc_op) ? ST_EXEC : ST_RESP;
         ST_EXEC:    if (settle_done) state_d = ST_CAPTURE;
         ST_CAPTURE: state_d = ST_RESP;
         ST_RESP:    if (rsp_fire) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      req0_ready = grant[0];
      req1_ready = grant[1];
      rsp0_valid = (state_q == ST_RESP) && !owner_q;
      rsp1_valid = (state_q == ST_RESP) &&  owner_q;
      busy       = (state_q != ST_IDLE);
      drive_alu  = (state_q == ST_EXEC) || (state_q == ST_CAPTURE);
   end

   // The ALU only sees the request while it is settling and being sampled.
   assign alu_sel      = drive_alu ? op_q : OP_NOP;
   assign alu_operand1 = drive_alu ? a_q  : '0;
   assign alu_operand2 = drive_alu ? b_q  : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q    <= 1'b0;
         op_q       <= OP_NOP;
         a_q        <= '0;
         b_q        <= '0;
         cnt_q      <= '0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         rsp_cmp    <= '0;
         rsp_err    <= 1'b0;
         flags_q    <= '0;
      end else begin
         if (|accept) begin
            owner_q <= accept[1];
            op_q    <= acc_op;
            a_q     <= acc_a;
            b_q     <= acc_b;
            cnt_q   <= '0;
            if (!is_legal_op(acc_op)) begin
               rsp_result <= '0;
               rsp_flags  <= '0;
               rsp_cmp    <= '0;
               rsp_err    <= 1'b1;
            end
         end
         if (state_q == ST_EXEC) cnt_q <= cnt_q + 4'd1;
         if (state_q == ST_CAPTURE) begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            rsp_cmp    <= {alu_eq, alu_gt, alu_lt};
            flags_q    <= alu_flags;
            rsp_err    <= ((op_q == OP_DIV) || (op_q == OP_MOD)) && (b_q == '0);
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized self-checking bench for alu_arbiter with a behavioural ALU and arbiter model
module tb_alu_arbiter;
   import alu_ops_pkg::*;

   localparam int S = 2;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [7:0]   req0_op, req1_op;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [W-1:0] rsp_result;
   logic [6:0]   rsp_flags;
   logic [2:0]   rsp_cmp;
   logic         rsp_err;
   logic [W-1:0] alu_operand1, alu_operand2, alu_result;
   logic [7:0]   alu_sel;
   logic [6:0]   alu_flags, flags_q;
   logic         alu_eq, alu_gt, alu_lt, busy;

   int           n_tests = 0;
   int           n_fail  = 0;
   int           last_grant;
   logic [6:0]   exp_flags;

   always #5 clk = ~clk;

   alu_arbiter #(.SETTLE_CYCLES(S), .WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_cmp(rsp_cmp), .rsp_err(rsp_err),
      .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_sel(alu_sel),
      .alu_result(alu_result), .alu_flags(alu_flags),
      .alu_eq(alu_eq), .alu_gt(alu_gt), .alu_lt(alu_lt),
      .flags_q(flags_q), .busy(busy)
   );

   // Stand-in ALU: {flags, result}; NOP drives recognisable junk.
   function automatic logic [14:0] alu_fn(input logic [7:0] sel, input logic [7:0] a, input logic [7:0] b);
      logic [8:0] wide;
      logic [7:0] r;
      logic [6:0] f;
      case (sel)
         OP_ADD:         wide = {1'b0, a} + {1'b0, b};
         OP_SUB, OP_CMP: wide = {1'b0, a} - {1'b0, b};
         OP_MULT:        wide = {1'b0, 8'(a * b)};
         OP_DIV:         wide = (b == 8'd0) ? 9'd0 : {1'b0, a / b};
         OP_MOD:         wide = (b == 8'd0) ? 9'd0 : {1'b0, a % b};
         OP_INC:         wide = {1'b0, a} + 9'd1;
         OP_DEC:         wide = {1'b0, a} - 9'd1;
         OP_SL:          wide = {a, 1'b0};
         OP_SR:          wide = {1'b0, a >> 1};
         OP_AND:         wide = {1'b0, a & b};
         OP_NAND:        wide = {1'b0, ~(a & b)};
         OP_NOR:         wide = {1'b0, ~(a | b)};
         OP_NOT:         wide = {1'b0, ~a};
         OP_OR:          wide = {1'b0, a | b};
         OP_XNOR:        wide = {1'b0, ~(a ^ b)};
         OP_XOR:         wide = {1'b0, a ^ b};
         OP_ROL:         wide = {1'b0, a[6:0], a[7]};
         OP_ROR:         wide = {1'b0, a[0], a[7:1]};
         default:        wide = 9'h0A5;
      endcase
      r = wide[7:0];
      f = '0;
      f[ZF] = (r == 8'd0);
      f[CF] = wide[8];
      f[SF] = r[7];
      f[PF] = ^r;
      if (sel == OP_NOP) f = 7'h55;
      return {f, r};
   endfunction

   assign {alu_flags, alu_result} = alu_fn(alu_sel, alu_operand1, alu_operand2);
   assign alu_eq = (alu_operand1 == alu_operand2);
   assign alu_gt = (alu_operand1 >  alu_operand2);
   assign alu_lt = (alu_operand1 <  alu_operand2);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One request on the chosen valids, response held for `hold` cycles, then consumed.
   task automatic transact(input bit v0, input bit v1, input int hold);
      int          w, k, lat;
      bit          seen, legal;
      logic [7:0]  op, a, b;
      logic [7:0]  e_res;
      logic [6:0]  e_flg;
      logic [2:0]  e_cmp;
      logic        e_err;
      logic [14:0] ex;
      w  = (v0 && v1) ? (1 - last_grant) : (v0 ? 0 : 1);
      op = w ? req1_op : req0_op;
      a  = w ? req1_a  : req0_a;
      b  = w ? req1_b  : req0_b;
      legal = ((op >= 8'h01) && (op <= 8'h12)) || (op == 8'h18);
      @(negedge clk);
      req0_valid = v0;
      req1_valid = v1;
      #1;
      check("req0_ready", req0_ready, w == 0);
      check("req1_ready", req1_ready, w == 1);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      last_grant = w;
      ex  = alu_fn(op, a, b);
      lat = legal ? S + 2 : 1;
      if (legal) begin
         e_res = ex[7:0];
         e_flg = ex[14:8];
         e_cmp = {a == b, a > b, a < b};
         e_err = ((op == 8'h04) || (op == 8'h05)) && (b == 8'd0);
         exp_flags = ex[14:8];
      end else begin
         e_res = 8'd0;
         e_flg = 7'd0;
         e_cmp = 3'd0;
         e_err = 1'b1;
      end
      seen = 1'b0;
      k = 0;
      while (!seen && k < 40) begin
         @(negedge clk);
         k++;
         check("nonowner_rsp_valid", w ? rsp0_valid : rsp1_valid, 1'b0);
         if (!legal) check("alu_sel_idle", alu_sel, OP_NOP);
         else if (k == 1) begin
            check("alu_sel", alu_sel, op);
            check("alu_operand1", alu_operand1, a);
            check("alu_operand2", alu_operand2, b);
         end
         if (w ? rsp1_valid : rsp0_valid) begin
            seen = 1'b1;
            check("rsp_latency", k, lat);
         end
      end
      if (!seen) begin
         check("rsp_timeout", 0, 1);
         return;
      end
      check("rsp_result", rsp_result, e_res);
      check("rsp_flags", rsp_flags, e_flg);
      check("rsp_cmp", rsp_cmp, e_cmp);
      check("rsp_err", rsp_err, e_err);
      check("flags_q", flags_q, exp_flags);
      repeat (hold) begin
         req0_valid = 1'b1;
         req1_valid = 1'b1;
         if (w) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
         #1;
         check("hold_req0_ready", req0_ready, 1'b0);
         check("hold_req1_ready", req1_ready, 1'b0);
         @(negedge clk);
         check("hold_busy", busy, 1'b1);
         check("hold_owner_valid", w ? rsp1_valid : rsp0_valid, 1'b1);
         check("hold_result", rsp_result, e_res);
         check("hold_err", rsp_err, e_err);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp0_ready = (w == 0);
      rsp1_ready = (w == 1);
      @(posedge clk);
      #1;
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      @(negedge clk);
      check("release_busy", busy, 1'b0);
      check("release_rsp0_valid", rsp0_valid, 1'b0);
      check("release_rsp1_valid", rsp1_valid, 1'b0);
   endtask

   function automatic logic [7:0] rand_op();
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) return ($urandom_range(0, 1) != 0) ? 8'(8'h13 + $urandom_range(0, 4)) : 8'(8'h19 + $urandom_range(0, 8'hE6));
      if (r == 19) return OP_CMP;
      return 8'(r);
   endfunction

   initial begin
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_op = 8'd0; req0_a = 8'd0; req0_b = 8'd0;
      req1_op = 8'd0; req1_a = 8'd0; req1_b = 8'd0;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      last_grant = 1;
      exp_flags = 7'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_busy", busy, 1'b0);
      check("reset_rsp_valids", {rsp0_valid, rsp1_valid}, 2'b00);
      check("reset_alu_sel", alu_sel, OP_NOP);
      check("reset_outputs", {rsp_result, rsp_flags, rsp_cmp, rsp_err, flags_q}, 0);
      rst = 1'b0;

      req0_op = OP_ADD; req0_a = 8'h05; req0_b = 8'h03;
      transact(1, 0, 0);

      for (int i = 0; i < 4; i++) begin
         req0_op = rand_op(); req0_a = 8'($urandom); req0_b = 8'($urandom);
         req1_op = rand_op(); req1_a = 8'($urandom); req1_b = 8'($urandom);
         transact(1, 1, 0);
      end

      req1_op = OP_SUB; req1_a = 8'h20; req1_b = 8'h21;
      transact(0, 1, 10);

      req0_op = OP_DIV; req0_a = 8'h10; req0_b = 8'h00;
      transact(1, 0, 0);

      req1_op = 8'hFF; req1_a = 8'h12; req1_b = 8'h34;
      transact(0, 1, 0);

      req0_op = OP_CMP; req0_a = 8'h07; req0_b = 8'h07;
      transact(1, 0, 0);

      for (int i = 0; i < 40; i++) begin
         int pick;
         pick = $urandom_range(1, 3);
         req0_op = rand_op(); req0_a = 8'($urandom);
         req0_b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
         req1_op = rand_op(); req1_a = 8'($urandom);
         req1_b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
         transact(pick[0], pick[1], $urandom_range(0, 3));
      end

      req0_op = OP_ADD; req0_a = 8'h80; req0_b = 8'h80;
      @(negedge clk);
      req0_valid = 1'b1;
      #1;
      check("pre_reset_ready", req0_ready, 1'b1);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("midreset_busy", busy, 1'b0);
      check("midreset_rsp_valids", {rsp0_valid, rsp1_valid}, 2'b00);
      check("midreset_alu", {alu_sel, alu_operand1, alu_operand2}, 0);
      check("midreset_outputs", {rsp_result, rsp_flags, rsp_cmp, rsp_err, flags_q}, 0);
      check("midreset_ready", {req0_ready, req1_ready}, 2'b00);
      last_grant = 1;
      exp_flags = 7'd0;
      repeat (8) begin
         @(negedge clk);
         check("midreset_no_rsp", rsp0_valid, 1'b0);
      end
      req1_op = OP_XOR; req1_a = 8'h5A; req1_b = 8'hFF;
      transact(0, 1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
